// File: rtl/mmu_weight_loader.sv
// rtl/mmu_weight_loader.sv - fetches an NxN weight tile row by row and shifts it into the PE array
module mmu_weight_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ARRAY_DIM  = 4,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  output logic                            busy,
  output logic                            done,
  output logic                            rd_req,
  output logic [ADDR_WIDTH-1:0]           rd_addr,
  input  logic                            rd_valid,
  input  logic [ARRAY_DIM*DATA_WIDTH-1:0] rd_data,
  output logic                            global_w_wen,
  output logic [ARRAY_DIM-1:0]            w_wen,
  output logic [ARRAY_DIM*DATA_WIDTH-1:0] w_out
);

  localparam int ROW_W = ARRAY_DIM * DATA_WIDTH;
  localparam int CNT_W = $clog2(ARRAY_DIM + 1);
  localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(ARRAY_DIM);
  localparam logic [CNT_W-1:0] LAST_RET = CNT_W'(ARRAY_DIM - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    DRAIN,
    DONE
  } state_t;

  state_t state_q, state_d;

  // Requests and returns are counted separately because memory latency is unknown.
  logic [CNT_W-1:0] req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;

  logic                  rd_req_d;
  logic [ADDR_WIDTH-1:0] rd_addr_d;
  logic [ROW_W-1:0]      w_out_d;
  logic                  ret_accept;
  logic                  last_ret;
  logic [ROW_W-1:0]      next_row;

  logic [ROW_W-1:0] row_buf [ARRAY_DIM];

  assign ret_accept = (state_q == FETCH) && rd_valid && (ret_cnt_q < N_CNT);
  assign last_ret   = ret_accept && (ret_cnt_q == LAST_RET);

  // Row to present on the next shift cycle: rows go out last-first.
  always_comb begin
    next_row = '0;
    for (int r = 0; r < ARRAY_DIM; r++) begin
      if (int'(step_cnt_q) == ARRAY_DIM - 2 - r) begin
        next_row = row_buf[r];
      end
    end
  end

  // Next-state, counter and registered-output precompute.
  always_comb begin
    state_d    = state_q;
    req_cnt_d  = req_cnt_q;
    ret_cnt_d  = ret_cnt_q;
    step_cnt_d = step_cnt_q;
    rd_req_d   = 1'b0;
    rd_addr_d  = '0;
    w_out_d    = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = FETCH;
          req_cnt_d = CNT_W'(1);
          ret_cnt_d = '0;
          rd_req_d  = 1'b1;
          rd_addr_d = base_addr;
        end
      end
      FETCH: begin
        if (req_cnt_q < N_CNT) begin
          rd_req_d  = 1'b1;
          rd_addr_d = rd_addr + ADDR_WIDTH'(1);
          req_cnt_d = req_cnt_q + CNT_W'(1);
        end
        if (ret_accept) begin
          ret_cnt_d = ret_cnt_q + CNT_W'(1);
        end
        if (last_ret) begin
          // The final row is still on rd_data, so it goes straight out as shift row 0.
          state_d    = SHIFT;
          step_cnt_d = '0;
          rd_req_d   = 1'b0;
          rd_addr_d  = '0;
          w_out_d    = rd_data;
        end
      end
      SHIFT: begin
        if (int'(step_cnt_q) < ARRAY_DIM - 1) begin
          step_cnt_d = step_cnt_q + CNT_W'(1);
          w_out_d    = next_row;
        end else if (ARRAY_DIM > 1) begin
          state_d    = DRAIN;
          step_cnt_d = '0;
        end else begin
          state_d = DONE;
        end
      end
      DRAIN: begin
        if (int'(step_cnt_q) < ARRAY_DIM - 2) begin
          step_cnt_d = step_cnt_q + CNT_W'(1);
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and all outputs registered; reset dominates everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_cnt_q    <= '0;
      ret_cnt_q    <= '0;
      step_cnt_q   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rd_req       <= 1'b0;
      rd_addr      <= '0;
      global_w_wen <= 1'b0;
      w_wen        <= '0;
      w_out        <= '0;
    end else begin
      state_q      <= state_d;
      req_cnt_q    <= req_cnt_d;
      ret_cnt_q    <= ret_cnt_d;
      step_cnt_q   <= step_cnt_d;
      busy         <= (state_d != IDLE);
      done         <= (state_d == DONE);
      rd_req       <= rd_req_d;
      rd_addr      <= rd_addr_d;
      global_w_wen <= (state_d == SHIFT) || (state_d == DRAIN);
      w_wen        <= (state_d == SHIFT) ? {ARRAY_DIM{1'b1}} : {ARRAY_DIM{1'b0}};
      w_out        <= w_out_d;
    end
  end

  // Row buffer k holds the k-th returned row; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    for (int r = 0; r < ARRAY_DIM; r++) begin
      if (ret_accept && (ret_cnt_q == CNT_W'(r))) begin
        row_buf[r] <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_mmu_weight_loader.sv
// tb/tb_mmu_weight_loader.sv - scoreboard bench for mmu_weight_loader at N=4 and N=1
`timescale 1ns/1ps
module tb_mmu_weight_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // N=4 instance
  logic        rst, start;
  logic [9:0]  base_addr;
  logic        busy, done, rd_req, rd_valid, global_w_wen;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, w_out;
  logic [3:0]  w_wen;

  mmu_weight_loader #(.DATA_WIDTH(16), .ARRAY_DIM(4), .ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .global_w_wen(global_w_wen),
    .w_wen(w_wen), .w_out(w_out)
  );

  // N=1 instance
  logic        start1;
  logic [9:0]  base1;
  logic        busy1, done1, rd_req1, rd_valid1, gw1;
  logic [9:0]  rd_addr1;
  logic [15:0] rd_data1, w_out1;
  logic [0:0]  w_wen1;

  mmu_weight_loader #(.DATA_WIDTH(16), .ARRAY_DIM(1), .ADDR_WIDTH(10)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .base_addr(base1),
    .busy(busy1), .done(done1), .rd_req(rd_req1), .rd_addr(rd_addr1),
    .rd_valid(rd_valid1), .rd_data(rd_data1), .global_w_wen(gw1),
    .w_wen(w_wen1), .w_out(w_out1)
  );

  function automatic logic [63:0] row_of(input logic [9:0] a);
    logic [63:0] r;
    for (int c = 0; c < 4; c++) r[c*16 +: 16] = {a[7:0], 6'(c), 2'b01};
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected output at cycle %0d", name, cyc);
  endtask

  // Scoreboard queues
  logic [9:0]  exp_addr_q [$];
  logic [63:0] exp_row_q [$];
  logic [9:0]  exp_addr1_q [$];
  logic [15:0] exp_row1_q [$];

  // Memory model configuration, written by stimulus only
  int lat = 1, gap_after = -1, gap_len = 0;
  int spur_req = 0;

  // Memory model state, written by the model only
  typedef struct {
    logic [63:0] data;
    int          ready;
  } resp_t;
  resp_t pend [$];
  int hold_until = 0, ret_total = 0, last_ret_cyc = -100, spur_done = 0;

  initial begin
    resp_t rsp;
    int k;
    rd_valid = 1'b0;
    rd_data  = '0;
    forever begin
      @(negedge clk);
      rd_valid = 1'b0;
      rd_data  = '0;
      if (rst === 1'b1) pend.delete();
      else if (rd_req === 1'b1) begin
        rsp.data  = row_of(rd_addr);
        rsp.ready = cyc + lat;
        pend.push_back(rsp);
      end
      if (pend.size() > 0 && pend[0].ready <= cyc && cyc >= hold_until) begin
        rsp = pend.pop_front();
        rd_valid = 1'b1;
        rd_data  = rsp.data;
        k = ret_total % 4;
        ret_total++;
        if (k == gap_after) hold_until = cyc + gap_len + 1;
        if (k == 3) last_ret_cyc = cyc;
      end else if (spur_req != spur_done) begin
        rd_valid = 1'b1;
        rd_data  = 64'hDEAD_BEEF_CAFE_F00D;
        spur_done++;
      end
    end
  end

  // N=4 monitor
  int shift_run = 0, drain_run = 0, done_seen = 0;
  logic prev_rst = 1'b0, prev_done = 1'b0, prev_wen = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (prev_rst) begin
        chk("reset_ctrl", 64'({busy, done, rd_req, global_w_wen, w_wen}), 64'(0));
        chk("reset_w_out", w_out, 64'(0));
        chk("reset_rd_addr", 64'(rd_addr), 64'(0));
      end
      if (rd_req === 1'b1) begin
        if (exp_addr_q.size() == 0) fail_now("unexpected_rd_req");
        else chk("rd_addr", 64'(rd_addr), 64'(exp_addr_q.pop_front()));
      end
      if (w_wen != 4'b0000) begin
        chk("shift_w_wen", 64'(w_wen), 64'hF);
        chk("shift_gw", 64'(global_w_wen), 64'(1));
        if (exp_row_q.size() == 0) fail_now("unexpected_shift");
        else chk("shift_w_out", w_out, exp_row_q.pop_front());
        if (shift_run == 0) chk("shift_start_cycle", 64'(cyc), 64'(last_ret_cyc + 1));
        else chk("shift_contiguous", 64'(prev_wen), 64'(1));
        shift_run++;
      end else if (global_w_wen === 1'b1) begin
        chk("drain_w_out", w_out, 64'(0));
        drain_run++;
      end
      if (done === 1'b1) begin
        chk("done_single_cycle", 64'(prev_done), 64'(0));
        chk("done_shift_len", 64'(shift_run), 64'(4));
        chk("done_drain_len", 64'(drain_run), 64'(3));
        chk("done_busy", 64'(busy), 64'(1));
        done_seen++;
        shift_run = 0;
        drain_run = 0;
      end
      prev_done = done;
      prev_wen  = (w_wen != 4'b0000);
      if (rst === 1'b1) begin
        exp_addr_q.delete();
        exp_row_q.delete();
        shift_run = 0;
        drain_run = 0;
      end
      prev_rst = rst;
    end
  end

  // N=1 memory model (fixed latency 1) and monitor
  logic        pend1_v = 1'b0;
  logic [15:0] pend1_d = '0;
  int shift1_n = 0, drain1_n = 0, done1_seen = 0, shift1_cyc = -100;

  initial begin
    logic [63:0] tmp;
    rd_valid1 = 1'b0;
    rd_data1  = '0;
    forever begin
      @(negedge clk);
      rd_valid1 = pend1_v;
      rd_data1  = pend1_d;
      tmp       = row_of(rd_addr1);
      pend1_v   = (rd_req1 === 1'b1) && (rst !== 1'b1);
      pend1_d   = tmp[15:0];
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rd_req1 === 1'b1) begin
        if (exp_addr1_q.size() == 0) fail_now("n1_unexpected_rd_req");
        else chk("n1_rd_addr", 64'(rd_addr1), 64'(exp_addr1_q.pop_front()));
      end
      if (w_wen1 === 1'b1) begin
        if (exp_row1_q.size() == 0) fail_now("n1_unexpected_shift");
        else chk("n1_w_out", 64'(w_out1), 64'(exp_row1_q.pop_front()));
        shift1_n++;
        shift1_cyc = cyc;
      end else if (gw1 === 1'b1) begin
        drain1_n++;
      end
      if (done1 === 1'b1) begin
        chk("n1_shift_len", 64'(shift1_n), 64'(1));
        chk("n1_no_drain", 64'(drain1_n), 64'(0));
        chk("n1_done_after_shift", 64'(cyc), 64'(shift1_cyc + 1));
        done1_seen++;
      end
    end
  end

  // Stimulus helpers
  task automatic load(input logic [9:0] b, input int l, input int ga, input int gl);
    lat       = l;
    gap_after = ga;
    gap_len   = gl;
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(b + 10'(i));
    for (int j = 0; j < 4; j++) exp_row_q.push_back(row_of(b + 10'(3 - j)));
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = b;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = 10'h155;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic wait_shift(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if (w_wen != 4'b0000) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL shift_timeout: no shift within %0d cycles", budget);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  int exp_done = 0;

  initial begin
    logic [63:0] tmp;
    bit seen1;
    rst = 1'b1; start = 1'b0; base_addr = '0; start1 = 1'b0; base1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Basic load, 1-cycle memory
    load(10'h010, 1, -1, 0);
    wait_done(40); exp_done++;

    // Latency 3 with a 2-cycle gap after row 1
    load(10'h020, 3, 1, 2);
    wait_done(60); exp_done++;

    // Address wrap
    load(10'h3FE, 2, -1, 0);
    wait_done(60); exp_done++;

    // Starts during FETCH, SHIFT and DONE are ignored
    load(10'h100, 1, -1, 0);
    @(posedge clk); #1; start = 1'b1; base_addr = 10'h200;
    @(posedge clk); #1; start = 1'b0;
    wait_shift(40);
    @(posedge clk); #1; start = 1'b1; base_addr = 10'h200;
    @(posedge clk); #1; start = 1'b0;
    wait_done(40); exp_done++;
    lat = 1; gap_after = -1;
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(10'h040 + 10'(i));
    for (int j = 0; j < 4; j++) exp_row_q.push_back(row_of(10'h040 + 10'(3 - j)));
    start = 1'b1; base_addr = 10'h040;
    @(posedge clk); #1;
    chk("idle_after_done", 64'(busy), 64'(0));
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart_busy", 64'(busy), 64'(1));
    wait_done(40); exp_done++;

    // Reset in shift cycle 2, together with a start that must lose
    load(10'h080, 1, -1, 0);
    wait_shift(40);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; base_addr = 10'h300;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    spur_req++;
    repeat (4) @(posedge clk);
    #1;
    chk("post_reset_busy", 64'(busy), 64'(0));
    chk("post_reset_rd_req", 64'(rd_req), 64'(0));
    chk("post_reset_gw", 64'(global_w_wen), 64'(0));

    // Clean full load after reset
    load(10'h0F0, 1, -1, 0);
    wait_done(40); exp_done++;

    // ARRAY_DIM=1 instance
    exp_addr1_q.push_back(10'h02A);
    tmp = row_of(10'h02A);
    exp_row1_q.push_back(tmp[15:0]);
    @(posedge clk); #1; start1 = 1'b1; base1 = 10'h02A;
    @(posedge clk); #1; start1 = 1'b0;
    seen1 = 1'b0;
    for (int i = 0; i < 20 && !seen1; i++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1) seen1 = 1'b1;
    end
    chk("n1_done_seen", 64'(seen1), 64'(1));
    repeat (3) @(posedge clk);
    #1;

    chk("done_count", 64'(done_seen), 64'(exp_done));
    chk("n1_done_count", 64'(done1_seen), 64'(1));
    chk("addr_q_drained", 64'(exp_addr_q.size()), 64'(0));
    chk("row_q_drained", 64'(exp_row_q.size()), 64'(0));
    chk("n1_addr_q_drained", 64'(exp_addr1_q.size()), 64'(0));
    chk("n1_row_q_drained", 64'(exp_row1_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
